// File: rtl/div_mc_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// The DUTY register only exists when DIV_MC_DUTY_CFG_EN is defined.
package div_mc_pkg;

    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_RATIO  = 4'h1;
    localparam logic [3:0] REG_DUTY   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h3;

    localparam logic [7:0] ADDR_SYNC = 8'hF0;
    localparam logic [7:0] ADDR_ID   = 8'hF1;

    localparam logic [31:0] ID_VALUE = 32'h0D10_0002;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } chnl_state_t;

endpackage

// File: rtl/div_mc_chnl.sv
// One divider channel: enable/ratio shadows, period counter and registered outputs.
// DIV_MC_DUTY_CFG_EN adds a shadowed DUTY setting for the high time.
//
// state | meaning
// IDLE  | stopped, outputs low, counter held at 0
// RUN   | dividing; shadows load at the period boundary
// STOP  | en cleared; finishing the current period, then IDLE
module div_mc_chnl
    import div_mc_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             wr_ctrl,
    input  logic             wr_ratio,
`ifdef DIV_MC_DUTY_CFG_EN
    input  logic             wr_duty,
    output logic [DIV_W-1:0] duty_sh,
`endif
    input  logic             sync,
    input  logic [DIV_W-1:0] wdata,
    output logic             ctrl_en,
    output logic [DIV_W-1:0] ratio_sh,
    output logic             pending,
    output logic             div_en,
    output logic             div_clk,
    output logic             div_tick
);

    chnl_state_t      state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] ratio_act;
    logic [DIV_W-1:0] r_eff;
    logic [DIV_W-1:0] h_eff;
    logic             cnt_last;
    logic             en_next;
    logic             shadow_wr;
    logic             load;
    logic             to_idle;
`ifdef DIV_MC_DUTY_CFG_EN
    logic [DIV_W-1:0] duty_act;
`endif

    always_comb begin
        r_eff = (ratio_act < DIV_W'(2)) ? DIV_W'(2) : ratio_act;
`ifdef DIV_MC_DUTY_CFG_EN
        if (duty_act == '0)
            h_eff = DIV_W'(1);
        else if (duty_act >= r_eff)
            h_eff = r_eff - DIV_W'(1);
        else
            h_eff = duty_act;
        shadow_wr = wr_ratio | wr_duty;
`else
        h_eff     = r_eff >> 1;
        shadow_wr = wr_ratio;
`endif
        cnt_inc  = cnt + DIV_W'(1);
        cnt_last = (cnt == r_eff - DIV_W'(1));
        en_next  = wr_ctrl ? wdata[0] : ctrl_en;
        load     = 1'b0;
        to_idle  = 1'b0;
        case (state)
            ST_IDLE: load = wr_ctrl & wdata[0];
            default: begin
                // SYNC overrides a STOP boundary, so the channel restarts instead of halting
                to_idle = (state == ST_STOP) && cnt_last && !sync && !en_next;
                load    = sync || (cnt_last && !to_idle);
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ctrl_en   <= 1'b0;
            ratio_sh  <= DIV_W'(2);
            ratio_act <= DIV_W'(2);
`ifdef DIV_MC_DUTY_CFG_EN
            duty_sh   <= DIV_W'(1);
            duty_act  <= DIV_W'(1);
`endif
            pending   <= 1'b0;
            div_en    <= 1'b0;
            div_clk   <= 1'b0;
            div_tick  <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl_en <= wdata[0];
            if (wr_ratio)
                ratio_sh <= wdata;
`ifdef DIV_MC_DUTY_CFG_EN
            if (wr_duty)
                duty_sh <= wdata;
`endif
            // load takes the pre-write shadow, so a same-edge write waits for the next boundary
            if (load) begin
                ratio_act <= ratio_sh;
`ifdef DIV_MC_DUTY_CFG_EN
                duty_act  <= duty_sh;
`endif
            end

            if (shadow_wr && state != ST_IDLE && !to_idle)
                pending <= 1'b1;
            else if (load || to_idle)
                pending <= 1'b0;

            if (load) begin
                state    <= en_next ? ST_RUN : ST_STOP;
                cnt      <= '0;
                div_en   <= 1'b1;
                div_clk  <= 1'b1;
                div_tick <= 1'b1;
            end else if (to_idle) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                div_en   <= 1'b0;
                div_clk  <= 1'b0;
                div_tick <= 1'b0;
            end else if (state != ST_IDLE) begin
                state    <= en_next ? ST_RUN : ST_STOP;
                cnt      <= cnt_inc;
                div_clk  <= (cnt_inc < h_eff);
                div_tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_mc_top.sv
// Multi-channel clock divider: register decode, read mux and CH_NUM channel instances.
// Define DIV_MC_DUTY_CFG_EN to expose the per-channel DUTY register at offset 2.
module div_mc_top
    import div_mc_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int DIV_W      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic [1:0]            cmd_opt_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_data_i,
    output logic [DATA_WIDTH-1:0] cmd_rdata_o,
    output logic [CH_NUM-1:0]     div_en_o,
    output logic [CH_NUM-1:0]     div_clk_o,
    output logic [CH_NUM-1:0]     div_tick_o
);

    logic                  wr_cmd;
    logic                  sync;
    logic [ADDR_WIDTH-5:0] addr_ch;
    logic [3:0]            addr_reg;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    logic                  unused_data;

    logic [CH_NUM-1:0]            ch_en;
    logic [CH_NUM-1:0]            ch_pend;
    logic [CH_NUM-1:0][DIV_W-1:0] ch_ratio;
`ifdef DIV_MC_DUTY_CFG_EN
    logic [CH_NUM-1:0][DIV_W-1:0] ch_duty;
`endif

    assign wr_cmd      = (cmd_opt_i == CMD_WR);
    assign sync        = wr_cmd && (cmd_addr_i == ADDR_WIDTH'(ADDR_SYNC));
    assign addr_ch     = cmd_addr_i[ADDR_WIDTH-1:4];
    assign addr_reg    = cmd_addr_i[3:0];
    assign unused_data = ^cmd_data_i;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic hit;
        assign hit = wr_cmd && (addr_ch == (ADDR_WIDTH-4)'(i));

        div_mc_chnl #(.DIV_W(DIV_W)) u_chnl (
            .clk_i    (clk_i),
            .rst_n    (rst_n),
            .wr_ctrl  (hit && addr_reg == REG_CTRL),
            .wr_ratio (hit && addr_reg == REG_RATIO),
`ifdef DIV_MC_DUTY_CFG_EN
            .wr_duty  (hit && addr_reg == REG_DUTY),
            .duty_sh  (ch_duty[i]),
`endif
            .sync     (sync),
            .wdata    (cmd_data_i[DIV_W-1:0]),
            .ctrl_en  (ch_en[i]),
            .ratio_sh (ch_ratio[i]),
            .pending  (ch_pend[i]),
            .div_en   (div_en_o[i]),
            .div_clk  (div_clk_o[i]),
            .div_tick (div_tick_o[i])
        );
    end

    always_comb begin
        rdata_nxt = '0;
        if (cmd_addr_i == ADDR_WIDTH'(ADDR_ID))
            rdata_nxt = DATA_WIDTH'(ID_VALUE);
        for (int i = 0; i < CH_NUM; i++) begin
            if (addr_ch == (ADDR_WIDTH-4)'(i)) begin
                case (addr_reg)
                    REG_CTRL:   rdata_nxt = DATA_WIDTH'(ch_en[i]);
                    REG_RATIO:  rdata_nxt = DATA_WIDTH'(ch_ratio[i]);
`ifdef DIV_MC_DUTY_CFG_EN
                    REG_DUTY:   rdata_nxt = DATA_WIDTH'(ch_duty[i]);
`endif
                    REG_STATUS: rdata_nxt = DATA_WIDTH'({ch_pend[i], div_en_o[i]});
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            cmd_rdata_o <= '0;
        else if (cmd_opt_i == CMD_RD)
            cmd_rdata_o <= rdata_nxt;
    end

endmodule

// File: tb/tb_div_mc_top.sv
// Scoreboard bench for div_mc_top: stimulus queues expected reads and per-cycle
// channel waveforms; a negedge monitor pops and compares them.
module tb_div_mc_top;

    localparam int CH_NUM = 4;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cmd_opt_i = 2'b00;
    logic [7:0]  cmd_addr_i = 8'h00;
    logic [31:0] cmd_data_i = 32'h0;
    logic [31:0] cmd_rdata_o;
    logic [CH_NUM-1:0] div_en_o;
    logic [CH_NUM-1:0] div_clk_o;
    logic [CH_NUM-1:0] div_tick_o;

    div_mc_top #(.CH_NUM(CH_NUM), .DIV_W(8), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .cmd_opt_i   (cmd_opt_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_rdata_o (cmd_rdata_o),
        .div_en_o    (div_en_o),
        .div_clk_o   (div_clk_o),
        .div_tick_o  (div_tick_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 0: read data, 1: {en,clk,tick} of one channel
        int          ch;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void cmp(string name, int ch, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ch=%0d cyc=%0d got=%0h expected=%0h", name, ch, cyc, act, exp);
        end
    endfunction

    // Without the duty feature H=R/2; with it, DUTY stays at its reset value 1.
    function automatic int exp_h(int r);
`ifdef DIV_MC_DUTY_CFG_EN
        return 1;
`else
        return r / 2;
`endif
    endfunction

    task automatic push(int c, int kind, int ch, logic [31:0] e);
        exp_t x;
        x.cyc = c; x.kind = kind; x.ch = ch; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_wave(int ch, int start, int r, int h, int periods);
        int m;
        for (int k = 0; k < r * periods; k++) begin
            m = k % r;
            push(start + k, 1, ch, {29'd0, 1'b1, (m < h), (m == 0)});
        end
    endtask

    task automatic push_zero(int ch, int start, int n);
        for (int k = 0; k < n; k++) push(start + k, 1, ch, 32'h0);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
        cmd_opt_i  = op;
        cmd_addr_i = a;
        cmd_data_i = d;
        @(negedge clk_i);
        cmd_opt_i  = 2'b00;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cmd(2'b01, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e);
        push(cyc + 1, 0, int'(a), e);
        cmd(2'b10, a, 32'h0);
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                if (sb[i].kind == 0)
                    cmp("rdata", sb[i].ch, cmd_rdata_o, sb[i].exp);
                else
                    cmp("wave", sb[i].ch,
                        {29'd0, div_en_o[sb[i].ch], div_clk_o[sb[i].ch], div_tick_o[sb[i].ch]},
                        sb[i].exp);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int s;

        // reset: everything low during and right after reset
        for (int c = 1; c <= 2; c++) begin
            for (int ch = 0; ch < CH_NUM; ch++) push(c, 1, ch, 32'h0);
            push(c, 0, 0, 32'h0);
        end
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        for (int ch = 0; ch < CH_NUM; ch++) push_zero(ch, cyc + 1, 2);

        rd(8'hF1, 32'h0D10_0002);
        rd(8'h01, 32'd2);
        rd(8'h00, 32'd0);
        rd(8'h03, 32'd0);
`ifdef DIV_MC_DUTY_CFG_EN
        rd(8'h02, 32'd1);
`else
        rd(8'h02, 32'd0);
`endif
        rd(8'h45, 32'd0);
        rd(8'hF0, 32'd0);

        // ch0 ratio 4
        wr(8'h01, 32'd4);
        e = cyc + 1;
        push_wave(0, e, 4, exp_h(4), 3);
        wr(8'h00, 32'd1);
        rd(8'h03, 32'd1);
        rd(8'h01, 32'd4);
        wait_cyc(e + 12);

        // ch1 ratio 5, changed to 3 mid-period
        wr(8'h11, 32'd5);
        e = cyc + 1;
        push_wave(1, e, 5, exp_h(5), 1);
        push_wave(1, e + 5, 3, exp_h(3), 3);
        wr(8'h10, 32'd1);
        @(negedge clk_i);
        wr(8'h11, 32'd3);
        rd(8'h13, 32'd3);
        wait_cyc(e + 6);
        rd(8'h13, 32'd1);
        wait_cyc(e + 14);

        // ch2 ratio 8, disable at cnt=2: full period then idle
        wr(8'h21, 32'd8);
        e = cyc + 1;
        push_wave(2, e, 8, exp_h(8), 1);
        push_zero(2, e + 8, 4);
        wr(8'h20, 32'd1);
        @(negedge clk_i);
        wr(8'h20, 32'd0);
        rd(8'h23, 32'd1);
        wait_cyc(e + 9);
        rd(8'h23, 32'd0);
        wait_cyc(e + 12);

        // SYNC phase-aligns ch0 (ratio 3) and ch1 (ratio 6)
        wr(8'h01, 32'd3);
        wr(8'h11, 32'd6);
        s = cyc + 1;
        push_wave(0, s, 3, exp_h(3), 3);
        push_wave(1, s, 6, exp_h(6), 2);
        push_zero(2, s, 3);
        wr(8'hF0, 32'd1);
        rd(8'h03, 32'd1);
        rd(8'hF0, 32'd0);
        wait_cyc(s + 12);

`ifdef DIV_MC_DUTY_CFG_EN
        // ch3 ratio 6 with duty 5, then 0, then 9 (clamped to 5)
        wr(8'h31, 32'd6);
        wr(8'h32, 32'd5);
        e = cyc + 1;
        push_wave(3, e, 6, 5, 1);
        push_wave(3, e + 6, 6, 1, 1);
        push_wave(3, e + 12, 6, 5, 2);
        wr(8'h30, 32'd1);
        wr(8'h32, 32'd0);
        wait_cyc(e + 7);
        wr(8'h32, 32'd9);
        rd(8'h32, 32'd9);
        wait_cyc(e + 24);
`else
        // ch3 odd ratio 7, then ratio 0 (effective 2)
        wr(8'h31, 32'd7);
        e = cyc + 1;
        push_wave(3, e, 7, 3, 2);
        push_wave(3, e + 14, 2, 1, 3);
        wr(8'h30, 32'd1);
        wait_cyc(e + 8);
        wr(8'h31, 32'd0);
        rd(8'h31, 32'd0);
        rd(8'h32, 32'd0);
        wait_cyc(e + 20);
`endif

        // asynchronous reset while channels are running
        for (int ch = 0; ch < CH_NUM; ch++) push(cyc + 1, 1, ch, 32'h0);
        push(cyc + 1, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1 cmp("async_rst_en", 0, {28'd0, div_en_o}, 32'h0);
        cmp("async_rst_clk", 0, {28'd0, div_clk_o}, 32'h0);
        @(negedge clk_i);
        #1;
        cmp("leftover", 0, sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_mc_top.md
Name: div_mc_top

Overview:
- Multi-channel, register-programmed clock divider; parametrised successor of the single-channel div_top.
- CH_NUM independent channels divide clk_i by a programmable ratio. Each channel drives div_clk_o, div_en_o and a one-cycle rising-edge tick.
- Ratio changes and disables take effect only at period boundaries (glitch-free).
- Configured through the same cmd/addr/wdata/rdata register port used across the platform.

Parameters:
- CH_NUM, 4, number of divider channels (1..15)
- DIV_W, 8, ratio/duty counter width
- ADDR_WIDTH, 8, register address width
- DATA_WIDTH, 32, register data width (>= DIV_W)

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_opt_i  in  2  command: 2'b00 idle, 2'b01 write, 2'b10 read, 2'b11 reserved (treated as idle)
- cmd_addr_i  in  ADDR_WIDTH  register address
- cmd_data_i  in  DATA_WIDTH  write data
- cmd_rdata_o  out  DATA_WIDTH  read data
- div_en_o  out  CH_NUM  per-channel running flag
- div_clk_o  out  CH_NUM  per-channel divided clock (registered)
- div_tick_o  out  CH_NUM  one-cycle pulse coincident with each div_clk_o rising edge

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_n.
- Reset values: all outputs 0; CTRL 0; RATIO 2; DUTY 1; counters 0.
- Address decode: addr[7:4] selects the channel; addr[3:0] selects the register.
  - 0 CTRL (RW, bit0 en)
  - 1 RATIO (RW, DIV_W)
  - 2 DUTY (RW, feature only)
  - 3 STATUS (RO: bit0 running, bit1 ratio_pending)
- Global registers:
  - 0xF0 SYNC: write-1 pulse, reads 0.
  - 0xF1 ID: RO 32'h0D1V_0002 encoded as 32'h0D100002.
- Unmapped or out-of-range addresses: reads return 0, writes ignored.
- Write timing: takes effect at the clk_i edge sampling cmd_opt_i=01.
- Read timing: cmd_rdata_o is registered, valid the cycle after the read is sampled, and holds until the next read.
- Effective ratio R = max(RATIO, 2).
- High time H:
  - Without the feature: H = R>>1. Odd R gives high for floor(R/2) cycles, low for the remainder.
- Channel FSM:
  - IDLE: cnt=0, div_clk_o=0, div_en_o=0.
    - CTRL.en write 1 -> RUN.
    - Active ratio and duty load from the shadow registers.
    - Next cycle: cnt=0, div_clk_o=1, div_tick_o=1, div_en_o=1.
  - RUN: cnt increments modulo R; div_clk_o = (cnt < H).
    - At cnt==R-1, the pending shadow RATIO/DUTY is loaded; ratio_pending clears.
    - en cleared -> STOP.
  - STOP: keeps counting until cnt==R-1, then -> IDLE. div_en_o and div_clk_o are 0 from the following cycle; no truncated high phase.
    - en re-set to 1 while in STOP -> RUN; the current period completes uninterrupted.
- RATIO write while in RUN: stored as shadow; ratio_pending=1 until the boundary.
- SYNC write: every channel in RUN/STOP restarts at cnt=0 on the next cycle, with div_tick_o asserted. The active ratio is reloaded from the shadow. This phase-aligns all channels.
- Simultaneous period boundary and SYNC: SYNC wins; the result is identical (cnt=0, tick).
- Simultaneous register write and boundary on the same channel: the new value becomes the shadow and applies at the next boundary, not the current one.
- Reset mid-operation: immediate return to reset values, independent of clk_i.

Optional Feature:
- Macro: DIV_MC_DUTY_CFG_EN.
- Defined:
  - DUTY register present at offset 2.
  - H = DUTY clamped to [1, R-1], shadowed like RATIO.
- Undefined:
  - Offset 2 is unmapped (reads 0).
  - H = R>>1.

Decomposition:
- div_mc_pkg holds:
  - cmd encoding constants (CMD_IDLE/WR/RD)
  - register offsets (REG_CTRL, REG_RATIO, REG_DUTY, REG_STATUS, ADDR_SYNC, ADDR_ID)
  - ID value
  - channel state enum typedef (IDLE, RUN, STOP)
- Sub-module div_mc_chnl: one channel, containing FSM, counter, shadow registers and outputs.
  - It is instantiated CH_NUM times from a generate loop in div_mc_top.
  - div_mc_top holds the register decode and the read mux.

Test Plan:
- Reset, read ID at 0xF1 -> cmd_rdata_o=32'h0D100002 one cycle later; all div_* outputs 0 during and after reset.
- Ch0 RATIO=4, en=1 -> div_clk_o[0] pattern 1100 repeating; a tick every 4 cycles; div_en_o[0]=1 one cycle after the write.
- Ch1 RATIO=5, running -> high 2 / low 3. Write RATIO=3 mid-period -> ratio_pending=1 and the current 5-cycle period completes; then high 1 / low 2.
- Ch2 RATIO=8, clear en at cnt=2 -> the output finishes the period (low through cnt=7), then div_en_o[2]=0; no pulse shorter than 4 cycles high.
- Ch0 RATIO=3, ch1 RATIO=6, both running, write SYNC -> both assert div_tick_o on the same cycle and both restart at cnt=0.
- With DIV_MC_DUTY_CFG_EN: RATIO=6, DUTY=5 -> high 5 / low 1; DUTY=0 -> high 1; DUTY=9 -> clamped to high 5.
